// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, default sizes and priority encoder for the speaker scheduler
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int DIV_W_DEF = 17;
    localparam int DUR_W_DEF = 26;
    localparam int GAP_DEF   = 16;
    localparam int ID_W      = 2;

    // Lowest set index wins; index 0 is the highest priority requester.
    function automatic logic [ID_W-1:0] prio_enc(input logic [N_REQ_DEF-1:0] v);
        prio_enc = '0;
        for (int i = N_REQ_DEF - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/sfx_scheduler_tone_gen.sv
// rtl/sfx_scheduler_tone_gen.sv - half-period counter and square-wave phase for the granted sound
module tone_gen
    import sfx_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] hp,
    output logic             wave_next
);

    logic [DIV_W-1:0] hp_q;
    logic [DIV_W-1:0] cnt;
    logic             phase;

    // A zero half-period is a rest, so the phase never leaves 0.
    always_comb begin
        wave_next = 1'b0;
        if (run && hp_q != '0) begin
            wave_next = (cnt == '0) ? ~phase : phase;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hp_q  <= '0;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (load) begin
            hp_q  <= hp;
            cnt   <= hp - 1'b1;
            phase <= 1'b0;
        end else if (run) begin
            phase <= wave_next;
            if (cnt == '0) begin
                cnt <= hp_q - 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else begin
            phase <= 1'b0;
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - fixed-priority, preemptive speaker arbiter with tone and duration timing
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int DUR_W      = DUR_W_DEF,
    parameter int GAP_CYCLES = GAP_DEF
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DIV_W-1:0] half_period,
    input  logic [N_REQ*DUR_W-1:0] duration,
    input  logic                   mute,
    output logic                   spk,
    output logic                   busy,
    output logic [ID_W-1:0]        active_id,
    output logic [N_REQ-1:0]       ack,
    output logic                   done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [DUR_W-1:0] dur_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [ID_W-1:0]  grant_id;
    logic [N_REQ-1:0] higher_mask;
    logic [N_REQ-1:0] grant_vec;
    logic             grant;
    logic             play_run;
    logic             wave_next;
    logic [DIV_W-1:0] hp_sel;
    logic [DUR_W-1:0] dur_sel;

    always_comb begin
        grant_id    = prio_enc(pending);
        higher_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i < int'(active_id)) higher_mask[i] = 1'b1;
        end
        // From IDLE any pending request wins; in PLAY only a strictly higher priority one preempts.
        grant = ((state == IDLE) && (pending != '0)) ||
                ((state == PLAY) && ((pending & higher_mask) != '0));
        grant_vec = '0;
        if (grant) grant_vec[grant_id] = 1'b1;
        hp_sel   = half_period[int'(grant_id)*DIV_W +: DIV_W];
        dur_sel  = duration[int'(grant_id)*DUR_W +: DUR_W];
        play_run = (state == PLAY) && !grant;
    end

    tone_gen #(
        .DIV_W(DIV_W)
    ) u_tone (
        .clk      (clk),
        .clr      (clr),
        .load     (grant),
        .run      (play_run),
        .hp       (hp_sel),
        .wave_next(wave_next)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            pending   <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            spk       <= 1'b0;
            busy      <= 1'b0;
            active_id <= '0;
            ack       <= '0;
            done      <= 1'b0;
        end else begin
            // A request arriving on its own grant edge survives and replays later.
            pending <= (pending & ~grant_vec) | req;
            ack     <= grant_vec;
            done    <= 1'b0;
            if (grant) begin
                state     <= PLAY;
                busy      <= 1'b1;
                active_id <= grant_id;
                spk       <= 1'b0;
                dur_cnt   <= (dur_sel == '0) ? '0 : dur_sel - 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        if (dur_cnt == '0) begin
                            spk  <= 1'b0;
                            done <= 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= GAP_LOAD;
                            end
                        end else begin
                            dur_cnt <= dur_cnt - 1'b1;
                            spk     <= wave_next & ~mute;
                        end
                    end
                    GAP: begin
                        spk <= 1'b0;
                        if (gap_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: begin
                        spk <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - self-checking bench for sfx_scheduler against a cycle-level behavioural model
module tb_sfx_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 17;
    localparam int UW  = 26;
    localparam int GAP = 16;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [NR-1:0]    req = '0;
    logic             mute = 1'b0;
    logic [DW-1:0]    hp_a [NR];
    logic [UW-1:0]    dur_a[NR];
    logic [NR*DW-1:0] half_period;
    logic [NR*UW-1:0] duration;
    logic             spk, busy, done;
    logic [1:0]       active_id;
    logic [NR-1:0]    ack;
    logic [8:0]       obs;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: state 0 idle, 1 play, 2 gap; m_k = current play cycle, m_g = current gap cycle.
    int         m_state = 0;
    logic [3:0] m_pend = '0;
    int         m_id = 0, m_hp = 0, m_len = 0, m_k = 0, m_g = 0;
    logic       m_spk = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [3:0] m_ack = '0;

    always #5 clk = ~clk;

    always_comb begin
        half_period = '0;
        duration    = '0;
        for (int i = 0; i < NR; i++) begin
            half_period[i*DW +: DW] = hp_a[i];
            duration[i*UW +: UW]    = dur_a[i];
        end
    end

    assign obs = {spk, busy, active_id, ack, done};

    sfx_scheduler dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .half_period(half_period),
        .duration   (duration),
        .mute       (mute),
        .spk        (spk),
        .busy       (busy),
        .active_id  (active_id),
        .ack        (ack),
        .done       (done)
    );

    function automatic logic [8:0] exp_vec();
        return {m_spk, m_busy, 2'(m_id), m_ack, m_done};
    endfunction

    task automatic model_edge();
        int         gid;
        logic       g;
        logic [3:0] gmask;
        if (clr) begin
            m_state = 0; m_pend = '0; m_id = 0; m_k = 0; m_g = 0;
            m_spk = 1'b0; m_busy = 1'b0; m_ack = '0; m_done = 1'b0;
            return;
        end
        gid = NR;
        for (int i = NR - 1; i >= 0; i--) if (m_pend[i]) gid = i;
        g = (gid < NR) && (m_state == 0 || (m_state == 1 && gid < m_id));
        gmask = g ? 4'(1 << gid) : 4'b0000;
        m_pend = (m_pend & ~gmask) | req;
        m_ack  = gmask;
        m_done = 1'b0;
        if (g) begin
            m_state = 1; m_id = gid; m_hp = int'(hp_a[gid]);
            m_len = (dur_a[gid] == '0) ? 1 : int'(dur_a[gid]);
            m_k = 1; m_spk = 1'b0;
        end else if (m_state == 1) begin
            if (m_k == m_len) begin
                m_done = 1'b1; m_spk = 1'b0; m_g = 1;
                m_state = (GAP > 0) ? 2 : 0;
            end else begin
                m_k++;
                m_spk = !mute && m_hp > 0 && (((m_k - 1) / m_hp) % 2 == 1);
            end
        end else if (m_state == 2) begin
            if (m_g == GAP) m_state = 0;
            else m_g++;
        end
        m_busy = (m_state != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_clr();
        clr = 1'b1; req = '0; mute = 1'b0;
        tick(); tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        apply_clr();
        n_cmp++;
        if (obs !== 9'd0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset obs=%h exp=%h", obs, 9'd0);
        end
    endtask

    task automatic test_basic();
        logic [19:0] pat;
        pat = 20'b00111000111000111000;
        apply_clr();
        hp_a[2] = 3; dur_a[2] = 20;
        req = 4'b0100; tick(); req = '0;
        n_cmp++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_ack ack=%b busy=%b exp 0000/0", ack, busy);
        end
        tick();
        n_cmp++;
        if (ack !== 4'b0100 || active_id !== 2'd2) begin
            n_fail++; $display("FAIL basic_ack ack=%b id=%0d exp 0100/2", ack, active_id);
        end
        for (int k = 1; k <= 20; k++) begin
            n_cmp++;
            if (spk !== pat[k-1] || obs !== exp_vec()) begin
                n_fail++; $display("FAIL basic_play k=%0d spk=%b exp=%b obs=%h model=%h", k, spk, pat[k-1], obs, exp_vec());
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_done done=%b busy=%b exp 1/1", done, busy);
        end
        for (int j = 1; j <= GAP; j++) begin
            n_cmp++;
            if (busy !== 1'b1 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL basic_gap j=%0d obs=%h exp=%h", j, obs, exp_vec());
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL basic_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        apply_clr();
        hp_a[1] = 2; dur_a[1] = 6; hp_a[3] = 4; dur_a[3] = 8;
        req = 4'b1010; tick(); req = '0; tick();
        n_cmp++;
        if (ack !== 4'b0010 || active_id !== 2'd1) begin
            n_fail++; $display("FAIL simul_first ack=%b id=%0d exp 0010/1", ack, active_id);
        end
        for (int t = 1; t <= 23; t++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec() || (t == 22 && busy !== 1'b0) ||
                (t == 23 && (ack !== 4'b1000 || active_id !== 2'd3)) || (t < 23 && ack !== 4'b0000)) begin
                n_fail++; $display("FAIL simul t=%0d obs=%h model=%h", t, obs, exp_vec());
            end
        end
        for (int t = 0; t < 26; t++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL simul_drain t=%0d obs=%h exp=%h", t, obs, exp_vec());
            end
        end
    endtask

    task automatic test_preempt();
        int n_done, n_ack;
        apply_clr();
        hp_a[3] = 5; dur_a[3] = 100; hp_a[0] = 2; dur_a[0] = 10;
        req = 4'b1000; tick(); req = '0; tick();
        for (int c = 2; c <= 10; c++) tick();
        req = 4'b0001; tick(); req = '0; tick();
        n_cmp++;
        if (ack !== 4'b0001 || spk !== 1'b0 || active_id !== 2'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL preempt_ack ack=%b spk=%b id=%0d done=%b exp 0001/0/0/0", ack, spk, active_id, done);
        end
        n_done = 0; n_ack = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (done === 1'b1) n_done++;
            if (ack !== 4'b0000) n_ack++;
            n_cmp++;
            if (obs !== exp_vec() || (t == 10 && done !== 1'b1)) begin
                n_fail++; $display("FAIL preempt t=%0d obs=%h model=%h", t, obs, exp_vec());
            end
        end
        n_cmp++;
        if (n_done != 1 || n_ack != 0) begin
            n_fail++; $display("FAIL preempt_counts done=%0d ack=%0d exp 1/0", n_done, n_ack);
        end
    endtask

    task automatic test_edges();
        apply_clr();
        hp_a[1] = 0; dur_a[1] = 5;
        req = 4'b0010; tick(); req = '0; tick();
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (spk !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL rest k=%0d obs=%h exp=%h", k, obs, exp_vec());
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL rest_done done=%b exp 1", done);
        end
        for (int t = 0; t < 17; t++) tick();
        hp_a[2] = 1; dur_a[2] = 0;
        req = 4'b0100; tick(); req = '0; tick();
        n_cmp++;
        if (ack !== 4'b0100 || spk !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL dur0_play ack=%b spk=%b done=%b exp 0100/0/0", ack, spk, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || spk !== 1'b0 || busy !== 1'b1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL dur0_done obs=%h exp=%h", obs, exp_vec());
        end
        for (int t = 0; t < 17; t++) tick();
    endtask

    task automatic test_clr_mid_play();
        apply_clr();
        hp_a[0] = 2; dur_a[0] = 50; hp_a[1] = 3; dur_a[1] = 4;
        req = 4'b0001; tick(); req = '0; tick();
        for (int c = 2; c <= 4; c++) tick();
        req = 4'b0010; tick(); req = '0; tick(); tick();
        n_cmp++;
        if (spk !== 1'b1 || active_id !== 2'd0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL clr_pre spk=%b id=%0d exp 1/0", spk, active_id);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        n_cmp++;
        if (spk !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || done !== 1'b0) begin
            n_fail++; $display("FAIL clr_now obs=%h exp spk/busy/ack/done all 0", obs);
        end
        for (int t = 1; t <= 60; t++) begin
            tick();
            n_cmp++;
            if (ack !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL clr_after t=%0d obs=%h exp=%h", t, obs, exp_vec());
            end
        end
    endtask

    task automatic test_rerequest();
        apply_clr();
        hp_a[2] = 3; dur_a[2] = 12;
        req = 4'b0100; tick(); req = '0; tick();
        for (int t = 1; t <= 30; t++) begin
            req = (t == 4) ? 4'b0100 : 4'b0000;
            tick();
            req = '0;
            n_cmp++;
            if (obs !== exp_vec() || ack !== ((t == 29) ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL rereq t=%0d ack=%b obs=%h model=%h", t, ack, obs, exp_vec());
            end
        end
        for (int t = 0; t < 30; t++) tick();
    endtask

    task automatic test_mute();
        logic [3:0] e_ack;
        logic       e_done, e_busy;
        apply_clr();
        mute = 1'b1;
        hp_a[2] = 3; dur_a[2] = 20;
        req = 4'b0100;
        for (int t = 1; t <= 40; t++) begin
            tick();
            req = '0;
            e_ack  = (t == 2) ? 4'b0100 : 4'b0000;
            e_done = (t == 22);
            e_busy = (t >= 2 && t <= 37);
            n_cmp++;
            if (spk !== 1'b0 || ack !== e_ack || done !== e_done || busy !== e_busy || obs !== exp_vec()) begin
                n_fail++; $display("FAIL mute t=%0d obs=%h exp ack=%b done=%b busy=%b", t, obs, e_ack, e_done, e_busy);
            end
        end
        mute = 1'b0;
    endtask

    task automatic test_random();
        apply_clr();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                hp_a[i]  = DW'($urandom_range(0, 4));
                dur_a[i] = UW'($urandom_range(0, 15));
                req[i]   = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 15) == 0) mute = ~mute;
            clr = ($urandom_range(0, 499) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random c=%0d obs=%h exp=%h", c, obs, exp_vec());
            end
        end
        clr = 1'b0; req = '0; mute = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            hp_a[i] = '0; dur_a[i] = '0;
        end
        test_reset();
        test_basic();
        test_simultaneous();
        test_preempt();
        test_edges();
        test_clr_mid_play();
        test_rerequest();
        test_mute();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
